// File: rtl/segstream_if.sv
// ----------------------------------------------------------------------------
// segstream_if
// Bundle between the 7-segment serial stream (loopback pins) and the
// segstream_rx receiver.
//   seg_in       serial segment data, bit j = digit lane j
//   shift_in     common shift clock, data valid on its rising edge
//   seg_pattern  latched byte {dp,g,f,e,d,c,b,a} per lane, lane j at [8j+:8]
//   digit_val    decoded hex value per lane, lane j at [4j+:4]
//   digit_ok     1 = lane pattern (dp ignored) is a valid hex glyph
//   frame_valid  1-cycle pulse when the outputs above update
//   frame_err    1-cycle pulse when a partial byte is dropped
// master: the side that drives the stream and observes the results.
// slave : the receiver.
// ----------------------------------------------------------------------------
interface segstream_if #(
    parameter int DIGITS = 2
);
    logic [DIGITS-1:0]   seg_in;
    logic                shift_in;
    logic [8*DIGITS-1:0] seg_pattern;
    logic [4*DIGITS-1:0] digit_val;
    logic [DIGITS-1:0]   digit_ok;
    logic                frame_valid;
    logic                frame_err;

    modport master (
        output seg_in,
        output shift_in,
        input  seg_pattern,
        input  digit_val,
        input  digit_ok,
        input  frame_valid,
        input  frame_err
    );

    modport slave (
        input  seg_in,
        input  shift_in,
        output seg_pattern,
        output digit_val,
        output digit_ok,
        output frame_valid,
        output frame_err
    );
endinterface

// File: rtl/segstream_rx.sv
// ----------------------------------------------------------------------------
// segstream_rx
// Receiver for the serial 7-segment stream produced by the display serialiser.
// Mimics the external shift-register chain: one serial data line per digit,
// one common shift clock. Each lane captures 8 bits MSB (dp) first, the
// complete byte is latched and decoded back to a 4-bit hex value so the
// counter/display path can be self-checked on chip.
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    segstream_if.slave:
//            seg_in, shift_in                          (in)
//            seg_pattern, digit_val, digit_ok,
//            frame_valid, frame_err                    (out)
//
// Parameters
//   DIGITS      number of digit lanes
//   GAP_CYCLES  idle clk cycles mid-byte before a partial byte is dropped
//   GAP_W       width of the gap counter (must hold GAP_CYCLES)
// ----------------------------------------------------------------------------
module segstream_rx #(
    parameter int DIGITS     = 2,
    parameter int GAP_CYCLES = 64,
    parameter int GAP_W      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    segstream_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;

    // Synchronisers: data and shift clock see identical 2-flop delay so the
    // data sample lines up with the detected rising edge.
    logic [DIGITS-1:0]   r_seg_s1;
    logic [DIGITS-1:0]   r_seg_s2;
    logic                r_shift_s1;
    logic                r_shift_s2;
    logic                r_shift_s3;
    logic                w_edge;

    logic [7:0]          r_shreg [DIGITS];
    logic [3:0]          r_bit_cnt;
    logic [3:0]          w_bit_cnt_nxt;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [GAP_W-1:0]    w_gap_inc;
    logic                w_shift_en;
    logic                w_latch;
    logic                w_abort;

    logic [8*DIGITS-1:0] r_seg_pattern;
    logic [4*DIGITS-1:0] r_digit_val;
    logic [DIGITS-1:0]   r_digit_ok;
    logic                r_frame_valid;
    logic                r_frame_err;

    logic [4*DIGITS-1:0] w_dec_val;
    logic [DIGITS-1:0]   w_dec_ok;
    logic [4:0]          w_dec;

    // Returns {ok, value}. Segments g..a active high; dp never reaches here.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisation and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_shift_s1 <= 1'b0;
            r_shift_s2 <= 1'b0;
            r_shift_s3 <= 1'b0;
        end else begin
            r_seg_s1   <= bus.seg_in;
            r_seg_s2   <= r_seg_s1;
            r_shift_s1 <= bus.shift_in;
            r_shift_s2 <= r_shift_s1;
            r_shift_s3 <= r_shift_s2;
        end
    end

    assign w_edge = r_shift_s2 & ~r_shift_s3;

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_gap     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_nxt     = r_gap;
        w_shift_en    = 1'b0;
        w_latch       = 1'b0;
        w_abort       = 1'b0;
        w_gap_inc     = r_gap + 1'b1;

        case (r_state)
            S_IDLE: begin
                w_bit_cnt_nxt = '0;
                w_gap_nxt     = '0;
                if (w_edge) begin
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = 4'd1;
                    w_state_nxt   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (w_edge) begin
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_gap_nxt     = '0;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nxt = S_LATCH;
                    end
                end else if (w_gap_inc == GAP_LIM) begin
                    // Stalled mid-byte: drop the partial byte.
                    w_abort       = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_gap_nxt     = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_gap_nxt = w_gap_inc;
                end
            end

            S_LATCH: begin
                w_latch       = 1'b1;
                w_bit_cnt_nxt = '0;
                w_gap_nxt     = '0;
                w_state_nxt   = S_IDLE;
                // An edge here already belongs to the next byte.
                if (w_edge) begin
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = 4'd1;
                    w_state_nxt   = S_SHIFT;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = '0;
                w_gap_nxt     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane shift registers (MSB first: first bit ends up in bit 7)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DIGITS; j++) begin
                r_shreg[j] <= '0;
            end
        end else if (w_abort) begin
            for (int j = 0; j < DIGITS; j++) begin
                r_shreg[j] <= '0;
            end
        end else if (w_shift_en) begin
            for (int j = 0; j < DIGITS; j++) begin
                r_shreg[j] <= {r_shreg[j][6:0], r_seg_s2[j]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the complete byte held in the shift registers
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_val = '0;
        w_dec_ok  = '0;
        w_dec     = '0;
        for (int j = 0; j < DIGITS; j++) begin
            w_dec             = f_decode(r_shreg[j][6:0]);
            w_dec_val[4*j+:4] = w_dec[3:0];
            w_dec_ok[j]       = w_dec[4];
        end
    end

    // ------------------------------------------------------------------
    // Output latch: updates only in LATCH, holds across frame errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_pattern <= '0;
            r_digit_val   <= '0;
            r_digit_ok    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_latch;
            r_frame_err   <= w_abort;
            if (w_latch) begin
                for (int j = 0; j < DIGITS; j++) begin
                    r_seg_pattern[8*j+:8] <= r_shreg[j];
                end
                r_digit_val <= w_dec_val;
                r_digit_ok  <= w_dec_ok;
            end
        end
    end

    assign bus.seg_pattern = r_seg_pattern;
    assign bus.digit_val   = r_digit_val;
    assign bus.digit_ok    = r_digit_ok;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_segstream_rx.sv
// ----------------------------------------------------------------------------
// tb_segstream_rx
// Directed bench for segstream_rx. A behavioural model predicts, from the
// time each shift-clock rising edge is driven on the pin, when frame_valid /
// frame_err must pulse and what the latched outputs must hold; a compare
// process checks the DUT against it every clock. Literal checks after each
// scenario pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_segstream_rx;

    localparam int DIGITS     = 2;
    localparam int GAP_CYCLES = 64;
    localparam int PIN_TO_OUT = 4;   // pin edge -> outputs/frame_valid
    localparam int PIN_TO_DET = 3;   // pin edge -> edge consumed by receiver

    logic clk = 1'b0;
    logic rst_n;

    segstream_if #(.DIGITS(DIGITS)) bus ();

    segstream_rx #(
        .DIGITS    (DIGITS),
        .GAP_CYCLES(GAP_CYCLES),
        .GAP_W     (7)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int n_fv     = 0;
    int n_fe     = 0;

    // Segment table g..a for 0..F
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int          due;
        logic [15:0] pat;
    } pend_t;

    pend_t       pend [$];
    logic [15:0] m_pat  = '0;
    int          fe_due = -1;
    int          last_rise = 0;

    function automatic logic [4:0] mdec(input logic [7:0] p);
        for (int k = 0; k < 16; k++) begin
            if (tbl[k] == p[6:0]) return {1'b1, 4'(k)};
        end
        return 5'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic       exp_fv;
        logic       exp_fe;
        logic [4:0] d0;
        logic [4:0] d1;
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (rst_n) begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_pat = pend[0].pat;
                void'(pend.pop_front());
                exp_fv = 1'b1;
            end
            exp_fe = (cyc == fe_due);
        end
        d0 = mdec(m_pat[7:0]);
        d1 = mdec(m_pat[15:8]);
        if (bus.frame_valid) n_fv++;
        if (bus.frame_err)   n_fe++;
        chk("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
        chk("frame_err",   32'(bus.frame_err),   32'(exp_fe));
        chk("seg_pattern", 32'(bus.seg_pattern), 32'(m_pat));
        chk("digit_val",   32'(bus.digit_val),   32'({d1[3:0], d0[3:0]}));
        chk("digit_ok",    32'(bus.digit_ok),    32'({d1[4], d0[4]}));
        if (bus.frame_valid && bus.frame_err) begin
            chk("valid_err_exclusive", 32'd1, 32'd0);
        end
    end

    // Drives nbits MSB first on both lanes; called at a negedge.
    task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                        input int nbits, input int half, input bit frame);
        for (int i = 0; i < nbits; i++) begin
            bus.seg_in   = {b1[7-i], b0[7-i]};
            bus.shift_in = 1'b0;
            repeat (half) @(negedge clk);
            bus.shift_in = 1'b1;
            last_rise    = cyc;
            if (frame && i == 7) begin
                pend.push_back('{due: cyc + PIN_TO_OUT, pat: {b1, b0}});
            end
            repeat (half) @(negedge clk);
        end
        bus.shift_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0;
        int fe0;
        rst_n        = 1'b0;
        bus.seg_in   = '0;
        bus.shift_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pattern", 32'(bus.seg_pattern), 32'h0);
        chk("reset_val",     32'(bus.digit_val),   32'h0);
        chk("reset_ok",      32'(bus.digit_ok),    32'h0);
        rst_n = 1'b1;
        idle(4);

        // Basic frame: 0x3F lane0, 0x06 lane1
        fv0 = n_fv;
        send(8'h3F, 8'h06, 8, 4, 1'b1);
        idle(4);
        chk("t2_pattern", 32'(bus.seg_pattern), 32'h063F);
        chk("t2_val",     32'(bus.digit_val),   32'h10);
        chk("t2_ok",      32'(bus.digit_ok),    32'b11);
        chk("t2_nframes", 32'(n_fv - fv0),      32'd1);

        // dp is masked on lane0; blank lane1 does not decode
        send(8'hBF, 8'h00, 8, 4, 1'b1);
        idle(4);
        chk("t3_val0",  32'(bus.digit_val[3:0]),    32'h0);
        chk("t3_ok",    32'(bus.digit_ok),          32'b01);
        chk("t3_pat1",  32'(bus.seg_pattern[15:8]), 32'h00);
        chk("t3_pat0",  32'(bus.seg_pattern[7:0]),  32'hBF);

        // Reset mid-byte: outputs drop immediately, partial byte lost
        send(8'h6D, 8'h4F, 3, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        pend.delete();
        m_pat  = '0;
        fe_due = -1;
        #1;
        chk("t1_async_pattern", 32'(bus.seg_pattern), 32'h0);
        chk("t1_async_ok",      32'(bus.digit_ok),    32'h0);
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        fv0 = n_fv;
        send(8'h6D, 8'h4F, 8, 4, 1'b1);
        idle(4);
        chk("t1_after_val",  32'(bus.digit_val), 32'h35);
        chk("t1_nframes",    32'(n_fv - fv0),    32'd1);

        // Stall mid-byte: frame_err once, outputs untouched, then recover
        fv0 = n_fv;
        fe0 = n_fe;
        send(8'h7F, 8'h7F, 5, 4, 1'b0);
        fe_due = last_rise + PIN_TO_DET + GAP_CYCLES;
        idle(GAP_CYCLES + 20);
        chk("t4_nerr",    32'(n_fe - fe0),      32'd1);
        chk("t4_nframes", 32'(n_fv - fv0),      32'd0);
        chk("t4_hold",    32'(bus.seg_pattern), 32'h4F6D);
        send(8'h77, 8'h7C, 8, 4, 1'b1);
        idle(4);
        chk("t4_recover_val", 32'(bus.digit_val), 32'hBA);

        // Back-to-back bytes at the fastest legal shift rate
        fv0 = n_fv;
        send(8'h39, 8'h5E, 8, 2, 1'b1);
        send(8'h79, 8'h71, 8, 2, 1'b1);
        idle(4);
        chk("t5_nframes", 32'(n_fv - fv0),      32'd2);
        chk("t5_pattern", 32'(bus.seg_pattern), 32'h7179);
        chk("t5_val",     32'(bus.digit_val),   32'hFE);

        // Sweep the whole table on both lanes
        for (int k = 0; k < 16; k++) begin
            send({1'b0, tbl[k]}, {1'b0, tbl[15-k]}, 8, 4, 1'b1);
            idle(4);
            chk("t6_val", 32'(bus.digit_val), 32'({4'(15 - k), 4'(k)}));
            chk("t6_ok",  32'(bus.digit_ok),  32'b11);
        end
        send(8'h00, 8'h7E, 8, 4, 1'b1);
        idle(4);
        chk("t6_bad_val", 32'(bus.digit_val), 32'h00);
        chk("t6_bad_ok",  32'(bus.digit_ok),  32'b00);
        chk("t6_pending", 32'(pend.size()),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
